cmd_desc_queue: RTL
===================

# cmd_desc_queue

Multi-channel successor to the single-set command register block. It holds N_CH independent shadow sets of Ethernet/IP/UDP/ARP header fields, all written from the 32-bit command bus. A send command atomically commits one channel's shadow set into its active set and queues a send descriptor. The packet generator drains the queue with a valid/ready handshake. The block also adds readback, a status word and drop accounting.

## Interface
- N_CH, 4, number of header channels, 1..8; channel = i_cmd_addr[7:5].
- CNT_W, 16, width of the saturating drop counter, at most 16.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- i_cmd_addr  in  8  [7:5] channel, [4:0] register offset.
- i_cmd_data  in  32  write data.
- i_cmd_wr  in  1  write strobe, single cycle.
- i_cmd_rd  in  1  read strobe, single cycle.
- o_cmd_rdata  out  32  read data.
- o_cmd_rvalid  out  1  read data valid.
- o_pkt_valid  out  1  descriptor available at queue head.
- i_pkt_ready  in  1  generator accepts head descriptor.
- o_pkt_ch  out  3  channel of head descriptor.
- o_pkt_type  out  2  1 = ARP, 2 = UDP.
- Active-set fields of the head channel:
  - o_dst_mac, o_src_mac, o_SHA, o_THA: 48 bits each.
  - o_src_ip, o_dst_ip, o_SPA, o_TPA: 32 bits each.
  - o_src_port, o_dst_port, o_udp_data_len: 16 bits each.
  - o_operation: 2 bits.

## Operation
- Register offsets, per channel:
  - 03/04: src_mac hi[47:16] / lo[15:0].
  - 05/06: dst_mac hi / lo.
  - 07: src_ip. 08: dst_ip.
  - 09: src_port. 0A: dst_port. 0C: udp_data_len.
  - 0D: arp operation [1:0].
  - 0E/0F: arp dst mac hi / lo. 10: arp dst ip.
  - 11/12: arp src mac hi / lo. 13: arp src ip.
  - Lo halves and 16-bit fields take data[15:0].
- Channel field ≥ N_CH: write ignored, read returns 0.
- Offset 02, send command, data[1:0]:
  - 1 or 2: if the channel's pending bit is clear, copy shadow→active, push {ch, type}, set pending.
  - Pending bit already set: drop the send; drop counter +1, saturating at all-ones.
  - 0 or 3: no effect.
- Offset 01 (channel field ignored):
  - Write with data[0]=1 clears the drop counter.
  - Read returns {drop[15:0] zero-extended, pending[7:0], level[3:0], 4'h0}.
- Reads of shadow registers return fields zero-extended to 32 bits. Unmapped offsets return 0.
- Queue is FIFO ordered, depth N_CH. One pending entry per channel, so it never overflows.
- Pop on o_pkt_valid & i_pkt_ready clears the pending bit of the popped channel.
- Reset: all shadow and active sets, pending bits, queue, drop counter, o_cmd_rdata and o_cmd_rvalid go to 0. o_pkt_valid = 0; head outputs read 0. Reset mid-handshake discards every queued descriptor.

## Timing
- Write at edge t: shadow updated at t+1.
- Send at t: active set, queue and pending bit updated at t+1. With the queue empty, o_pkt_valid=1 from t+1.
- Read at t: o_cmd_rdata and o_cmd_rvalid registered at t+1. o_cmd_rvalid is a one-cycle pulse. Read data reflects pre-edge state, so a read and a write in the same cycle return the old value.
- o_pkt_* are combinational from the queue head and active sets. They hold stable while valid and not accepted. The generator must latch them on the accepting edge.
- Pop and send to the same channel in one cycle: send accepted, no drop. The generator latches the pre-edge active set. The new entry queues behind remaining entries; the pending bit stays set.
- Pop and a dropped send in one cycle cannot occur for different channels' pending state. Pending state is evaluated pre-edge, except for the same-channel case above.
- Pop and push in the same cycle leave the level unchanged.

## Structure
- Package net_cmd_pkg holds:
  - Register offset localparams.
  - pkt_type_e enum: NONE, ARP, UDP, RSV.
  - hdr_t packed struct with all header fields.
  - Status-word bit positions.
- Sub-module cmd_desc_fifo: synchronous FIFO, parametrised width/depth, with level output, push/pop/empty/full. Same-cycle push+pop on empty is legal when the pop is gated by empty.
- Shadow and active storage are hdr_t arrays [N_CH].

## Test plan
- After reset, read offset 01 of ch0 → rvalid at t+1, rdata=0. o_pkt_valid=0.
- Write ch1: src_ip=0xC0A80001, udp_data_len=0x0100, then send 2 with i_pkt_ready=0 → next cycle o_pkt_valid=1, ch=1, type=2, src_ip=C0A80001, len=0100.
- With ch1 pending, send again to ch1 → status drop=1, pending=0x02, level=1. Write 01 with data=1 → drop=0.
- Queue sends to ch2 (ARP), ch0 (UDP), ch3 (UDP); pop with ready=1 → order 2, 0, 3. Level goes 3→0; pending clears bit by bit.
- Hold ready=1 and send ch1 in the same cycle as ch1 pops → no drop. Second descriptor for ch1 appears with the new active fields.
- Queue two descriptors, assert rst for one cycle → o_pkt_valid=0, all fields 0, level=0.

Source files
------------

// File: rtl/net_cmd_pkg.sv
// Shared definitions for the multi-channel command/descriptor queue:
// register offsets, packet type encoding, the header field bundle,
// status word layout and field read/write helpers for the register map.
package net_cmd_pkg;

  localparam int unsigned CMD_AW = 8;
  localparam int unsigned CMD_DW = 32;

  localparam logic [4:0] OFF_STATUS     = 5'h01;
  localparam logic [4:0] OFF_SEND       = 5'h02;
  localparam logic [4:0] OFF_SRC_MAC_HI = 5'h03;
  localparam logic [4:0] OFF_SRC_MAC_LO = 5'h04;
  localparam logic [4:0] OFF_DST_MAC_HI = 5'h05;
  localparam logic [4:0] OFF_DST_MAC_LO = 5'h06;
  localparam logic [4:0] OFF_SRC_IP     = 5'h07;
  localparam logic [4:0] OFF_DST_IP     = 5'h08;
  localparam logic [4:0] OFF_SRC_PORT   = 5'h09;
  localparam logic [4:0] OFF_DST_PORT   = 5'h0A;
  localparam logic [4:0] OFF_UDP_LEN    = 5'h0C;
  localparam logic [4:0] OFF_ARP_OPER   = 5'h0D;
  localparam logic [4:0] OFF_THA_HI     = 5'h0E;
  localparam logic [4:0] OFF_THA_LO     = 5'h0F;
  localparam logic [4:0] OFF_TPA        = 5'h10;
  localparam logic [4:0] OFF_SHA_HI     = 5'h11;
  localparam logic [4:0] OFF_SHA_LO     = 5'h12;
  localparam logic [4:0] OFF_SPA        = 5'h13;

  // Status word: {drop[31:16], pending[15:8], level[7:4], 4'h0}
  localparam int unsigned ST_DROP_LSB  = 16;
  localparam int unsigned ST_PEND_LSB  = 8;
  localparam int unsigned ST_LEVEL_LSB = 4;

  typedef enum logic [1:0] {
    PKT_NONE = 2'd0,
    PKT_ARP  = 2'd1,
    PKT_UDP  = 2'd2,
    PKT_RSV  = 2'd3
  } pkt_type_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [47:0] sha;
    logic [47:0] tha;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_data_len;
    logic [1:0]  operation;
  } hdr_t;

  // Apply one register write to a header set; non-field offsets leave it unchanged.
  function automatic hdr_t wr_field(input hdr_t h, input logic [4:0] off,
                                    input logic [31:0] d);
    hdr_t r;
    r = h;
    case (off)
      OFF_SRC_MAC_HI: r.src_mac[47:16] = d;
      OFF_SRC_MAC_LO: r.src_mac[15:0]  = d[15:0];
      OFF_DST_MAC_HI: r.dst_mac[47:16] = d;
      OFF_DST_MAC_LO: r.dst_mac[15:0]  = d[15:0];
      OFF_SRC_IP:     r.src_ip         = d;
      OFF_DST_IP:     r.dst_ip         = d;
      OFF_SRC_PORT:   r.src_port       = d[15:0];
      OFF_DST_PORT:   r.dst_port       = d[15:0];
      OFF_UDP_LEN:    r.udp_data_len   = d[15:0];
      OFF_ARP_OPER:   r.operation      = d[1:0];
      OFF_THA_HI:     r.tha[47:16]     = d;
      OFF_THA_LO:     r.tha[15:0]      = d[15:0];
      OFF_TPA:        r.tpa            = d;
      OFF_SHA_HI:     r.sha[47:16]     = d;
      OFF_SHA_LO:     r.sha[15:0]      = d[15:0];
      OFF_SPA:        r.spa            = d;
      default:        r = h;
    endcase
    return r;
  endfunction

  // Readback of one header field, zero-extended; unmapped offsets read 0.
  function automatic logic [31:0] rd_field(input hdr_t h, input logic [4:0] off);
    logic [31:0] r;
    r = 32'h0;
    case (off)
      OFF_SRC_MAC_HI: r = h.src_mac[47:16];
      OFF_SRC_MAC_LO: r = {16'h0, h.src_mac[15:0]};
      OFF_DST_MAC_HI: r = h.dst_mac[47:16];
      OFF_DST_MAC_LO: r = {16'h0, h.dst_mac[15:0]};
      OFF_SRC_IP:     r = h.src_ip;
      OFF_DST_IP:     r = h.dst_ip;
      OFF_SRC_PORT:   r = {16'h0, h.src_port};
      OFF_DST_PORT:   r = {16'h0, h.dst_port};
      OFF_UDP_LEN:    r = {16'h0, h.udp_data_len};
      OFF_ARP_OPER:   r = {30'h0, h.operation};
      OFF_THA_HI:     r = h.tha[47:16];
      OFF_THA_LO:     r = {16'h0, h.tha[15:0]};
      OFF_TPA:        r = h.tpa;
      OFF_SHA_HI:     r = h.sha[47:16];
      OFF_SHA_LO:     r = {16'h0, h.sha[15:0]};
      OFF_SPA:        r = h.spa;
      default:        r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_desc_queue_if.sv
// Command bus plus descriptor handshake with head-channel header fields.
// master: command host / packet generator side; slave: cmd_desc_queue.
interface cmd_desc_queue_if;
  logic [7:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        i_cmd_wr;
  logic        i_cmd_rd;
  logic [31:0] o_cmd_rdata;
  logic        o_cmd_rvalid;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic [2:0]  o_pkt_ch;
  logic [1:0]  o_pkt_type;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [31:0] o_src_ip, o_dst_ip, o_SPA, o_TPA;
  logic [15:0] o_src_port, o_dst_port, o_udp_data_len;
  logic [1:0]  o_operation;

  modport master (
    output i_cmd_addr, i_cmd_data, i_cmd_wr, i_cmd_rd, i_pkt_ready,
    input  o_cmd_rdata, o_cmd_rvalid, o_pkt_valid, o_pkt_ch, o_pkt_type,
    input  o_dst_mac, o_src_mac, o_SHA, o_THA, o_src_ip, o_dst_ip, o_SPA, o_TPA,
    input  o_src_port, o_dst_port, o_udp_data_len, o_operation
  );

  modport slave (
    input  i_cmd_addr, i_cmd_data, i_cmd_wr, i_cmd_rd, i_pkt_ready,
    output o_cmd_rdata, o_cmd_rvalid, o_pkt_valid, o_pkt_ch, o_pkt_type,
    output o_dst_mac, o_src_mac, o_SHA, o_THA, o_src_ip, o_dst_ip, o_SPA, o_TPA,
    output o_src_port, o_dst_port, o_udp_data_len, o_operation
  );
endinterface

// File: rtl/cmd_desc_fifo.sv
// Synchronous FIFO for send descriptors.
// Ports: clk, rst (sync, active-high), push/push_data, pop (ignored when
// empty), head_c (combinational head entry), empty_c, full_c, level.
module cmd_desc_fifo #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_c,
  output logic             empty_c,
  output logic             full_c,
  output logic [LVL_W-1:0] level
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_c = (level == '0);
  assign full_c  = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty_c;
  // A pop frees a slot in the same cycle, so push is legal even when full.
  assign do_push = push && (!full_c || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (!do_push && do_pop) level <= level - LVL_W'(1);
    end
  end
endmodule

// File: rtl/cmd_desc_queue.sv
// Multi-channel header register file with atomic shadow->active commit and
// an ordered send-descriptor queue for the packet generator.
// Ports: clk, rst (sync, active-high), bus (cmd_desc_queue_if.slave):
// command write/read with registered readback, descriptor valid/ready with
// combinational head channel, type and active header fields.
module cmd_desc_queue
  import net_cmd_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  cmd_desc_queue_if.slave bus
);
  localparam int unsigned LVL_W = $clog2(N_CH + 1);
  localparam int unsigned DSC_W = 5;

  hdr_t             shadow [N_CH];
  hdr_t             active [N_CH];
  logic [N_CH-1:0]  pending, pending_nx;
  logic [CNT_W-1:0] drop_cnt;

  logic [2:0]       ch, head_ch;
  logic [4:0]       off;
  logic [N_CH-1:0]  ch_oh, pop_oh;
  hdr_t             sel_shadow, head_hdr;
  logic [DSC_W-1:0] head_dsc;
  logic             fifo_empty, fifo_full;
  logic [LVL_W-1:0] level;
  logic             valid, pop, is_send, pend_cur, accept, drop, clr_drop;
  logic [31:0]      status, rd_mux;

  assign ch      = bus.i_cmd_addr[7:5];
  assign off     = bus.i_cmd_addr[4:0];
  assign head_ch = head_dsc[4:2];
  assign valid   = !fifo_empty;
  assign pop     = valid && bus.i_pkt_ready;

  // Addressed-channel and head-channel decode; out-of-range channels decode to nothing.
  always_comb begin
    ch_oh      = '0;
    pop_oh     = '0;
    sel_shadow = '0;
    head_hdr   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch == 3'(i)) begin
        ch_oh[i]   = 1'b1;
        sel_shadow = shadow[i];
      end
      if (valid && head_ch == 3'(i)) begin
        pop_oh[i] = 1'b1;
        head_hdr  = active[i];
      end
    end
  end

  // Send accept: pending bit is pre-edge, except a same-channel pop frees it now.
  assign is_send  = bus.i_cmd_wr && (off == OFF_SEND) && (|ch_oh) &&
                    (bus.i_cmd_data[1:0] == PKT_ARP || bus.i_cmd_data[1:0] == PKT_UDP);
  assign pend_cur = |(pending & ch_oh);
  assign accept   = is_send && (!pend_cur || (pop && head_ch == ch)) && (!fifo_full || pop);
  assign drop     = is_send && !accept;
  assign clr_drop = bus.i_cmd_wr && (off == OFF_STATUS) && bus.i_cmd_data[0];

  // Clear before set so a same-channel pop+send keeps the bit.
  assign pending_nx = (pending & ~(pop ? pop_oh : '0)) | (accept ? ch_oh : '0);

  assign status = (32'(drop_cnt) << ST_DROP_LSB) | (32'(pending) << ST_PEND_LSB) |
                  (32'(level) << ST_LEVEL_LSB);
  assign rd_mux = (off == OFF_STATUS) ? status :
                  (|ch_oh)            ? rd_field(sel_shadow, off) : 32'h0;

  cmd_desc_fifo #(.W(DSC_W), .DEPTH(N_CH), .LVL_W(LVL_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({ch, bus.i_cmd_data[1:0]}),
    .pop       (pop),
    .head_c    (head_dsc),
    .empty_c   (fifo_empty),
    .full_c    (fifo_full),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending          <= '0;
      drop_cnt         <= '0;
      bus.o_cmd_rdata  <= '0;
      bus.o_cmd_rvalid <= 1'b0;
    end else begin
      bus.o_cmd_rvalid <= bus.i_cmd_rd;
      if (bus.i_cmd_rd) bus.o_cmd_rdata <= rd_mux;
      pending <= pending_nx;
      if (clr_drop)                drop_cnt <= '0;
      else if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      for (int i = 0; i < int'(N_CH); i++) begin
        if (bus.i_cmd_wr && ch_oh[i]) shadow[i] <= wr_field(shadow[i], off, bus.i_cmd_data);
        if (accept && ch_oh[i])       active[i] <= shadow[i];
      end
    end
  end

  assign bus.o_pkt_valid    = valid;
  assign bus.o_pkt_ch       = valid ? head_ch : 3'd0;
  assign bus.o_pkt_type     = valid ? head_dsc[1:0] : 2'd0;
  assign bus.o_dst_mac      = head_hdr.dst_mac;
  assign bus.o_src_mac      = head_hdr.src_mac;
  assign bus.o_SHA          = head_hdr.sha;
  assign bus.o_THA          = head_hdr.tha;
  assign bus.o_src_ip       = head_hdr.src_ip;
  assign bus.o_dst_ip       = head_hdr.dst_ip;
  assign bus.o_SPA          = head_hdr.spa;
  assign bus.o_TPA          = head_hdr.tpa;
  assign bus.o_src_port     = head_hdr.src_port;
  assign bus.o_dst_port     = head_hdr.dst_port;
  assign bus.o_udp_data_len = head_hdr.udp_data_len;
  assign bus.o_operation    = head_hdr.operation;
endmodule
